// File: rtl/read_driver_pkg.sv
// ============================================================================
// Module   : read_driver_pkg
// Brief    : FSM state codes, ROM coefficients and ROM word function shared by
//            read_driver and read_driver_rom.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package read_driver_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int unsigned ROM_MUL = 29;
  localparam int unsigned ROM_ADD = 5;

  // Full-width word; callers keep the low DATA_W bits, which is the modulo.
  function automatic logic [31:0] rom_word(input int unsigned a);
    return ROM_MUL * a + ROM_ADD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/read_driver_rom.sv
// ============================================================================
// Module   : read_driver_rom
// Brief    : Fixed-content synchronous ROM, one-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module read_driver_rom
  import read_driver_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] rom_tbl [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam logic [31:0] C_WORD = rom_word(i);
    assign rom_tbl[i] = C_WORD[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (en) begin
      data <= rom_tbl[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/read_driver.sv
// ============================================================================
// Module   : read_driver
// Brief    : Sweeps the internal ROM once after reset, strobing each word with
//            its address and a running checksum; READ_DRIVER_LOOP_EN makes the
//            sweep repeat forever with a one-cycle o_done pulse per pass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module read_driver
  import read_driver_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W-1:0] o_data_addr,
  output logic [DATA_W-1:0] o_checksum,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  logic [1:0]        state_q,     state_d;
  logic              rd_en_q,     rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic              rd_valid_q,  rd_valid_d;
  logic [DATA_W-1:0] rd_data_q,   rd_data_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [DATA_W-1:0] checksum_q,  checksum_d;
  logic              done_q,      done_d;
  logic [DATA_W-1:0] rom_data;

  // The ROM is fed the next-cycle request so its word is ready on the edge
  // where o_rd_en/o_rd_addr are registered outputs; this keeps every output
  // in a reset flop while the ROM itself needs no reset.
  read_driver_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk  (i_CLK),
    .en   (rd_en_d),
    .addr (rd_addr_d),
    .data (rom_data)
  );

  always_comb begin
    state_d     = state_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    rd_valid_d  = rd_en_q;
    rd_data_d   = rd_data_q;
    data_addr_d = data_addr_q;
    checksum_d  = checksum_q;
    done_d      = done_q;

    if (rd_en_q) begin
      rd_data_d   = rom_data;
      data_addr_d = rd_addr_q;
      checksum_d  = checksum_q + rom_data;
    end

    case (state_q)
      IDLE: begin
        rd_en_d   = 1'b1;
        rd_addr_d = '0;
        state_d   = READ;
      end
      READ: begin
        if (rd_addr_q == ADDR_LAST) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
`ifdef READ_DRIVER_LOOP_EN
        done_d     = 1'b0;
        rd_en_d    = 1'b1;
        rd_addr_d  = '0;
        checksum_d = '0;
        state_d    = READ;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      data_addr_q <= '0;
      checksum_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      data_addr_q <= data_addr_d;
      checksum_q  <= checksum_d;
      done_q      <= done_d;
    end
  end

  assign o_rd_en     = rd_en_q;
  assign o_rd_addr   = rd_addr_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;
  assign o_data_addr = data_addr_q;
  assign o_checksum  = checksum_q;
  assign o_done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_read_driver.sv
// ============================================================================
// Module   : tb_read_driver
// Brief    : Self-checking bench for read_driver (default build and
//            READ_DRIVER_LOOP_EN build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_read_driver;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] checksum;
  logic              done;

  read_driver #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .o_rd_en     (rd_en),
    .o_rd_addr   (rd_addr),
    .o_rd_valid  (rd_valid),
    .o_rd_data   (rd_data),
    .o_data_addr (data_addr),
    .o_checksum  (checksum),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        en;
    logic [3:0]  addr;
    logic        valid;
    logic        dn;
    logic [7:0]  cs;
  } vec_t;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } exp_t;

  vec_t tbl [6];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_word(input int a);
    logic [31:0] w;
    w = 29 * a + 5;
    return w[7:0];
  endfunction

  task automatic push_sweep();
    for (int a = 0; a < DEPTH; a++) begin
      exp_t x;
      x.a = a[3:0];
      x.d = model_word(a);
      sb.push_back(x);
    end
  endtask

  task automatic monitor();
    if (rd_valid === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_valid: got addr 0x%0h expected no valid", data_addr);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("data_addr", 32'(data_addr), 32'(x.a));
        chk("rd_data",   32'(rd_data),   32'(x.d));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"},     32'(rd_en),     0);
    chk({tag, "_rd_addr"},   32'(rd_addr),   0);
    chk({tag, "_rd_valid"},  32'(rd_valid),  0);
    chk({tag, "_rd_data"},   32'(rd_data),   0);
    chk({tag, "_data_addr"}, 32'(data_addr), 0);
    chk({tag, "_checksum"},  32'(checksum),  0);
    chk({tag, "_done"},      32'(done),      0);
  endtask

  // Expects to be called at a negedge with reset asserted; releases it and
  // runs through edge 18 (done raised).
  task automatic sweep();
    n_valid = 0;
    push_sweep();
    rst = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      @(negedge clk);
      monitor();
      for (int r = 0; r < 6; r++) begin
        if (tbl[r].cyc == e) begin
          chk($sformatf("e%0d_rd_en", e),    32'(rd_en),    32'(tbl[r].en));
          chk($sformatf("e%0d_rd_addr", e),  32'(rd_addr),  32'(tbl[r].addr));
          chk($sformatf("e%0d_valid", e),    32'(rd_valid), 32'(tbl[r].valid));
          chk($sformatf("e%0d_done", e),     32'(done),     32'(tbl[r].dn));
          chk($sformatf("e%0d_checksum", e), 32'(checksum), 32'(tbl[r].cs));
        end
      end
    end
    chk("valid_count", n_valid, DEPTH);
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    tbl[0] = '{cyc: 1,  en: 1'b1, addr: 4'd0,  valid: 1'b0, dn: 1'b0, cs: 8'h00};
    tbl[1] = '{cyc: 2,  en: 1'b1, addr: 4'd1,  valid: 1'b1, dn: 1'b0, cs: 8'h05};
    tbl[2] = '{cyc: 3,  en: 1'b1, addr: 4'd2,  valid: 1'b1, dn: 1'b0, cs: 8'h27};
    tbl[3] = '{cyc: 16, en: 1'b1, addr: 4'd15, valid: 1'b1, dn: 1'b0, cs: 8'h30};
    tbl[4] = '{cyc: 17, en: 1'b0, addr: 4'd15, valid: 1'b1, dn: 1'b0, cs: 8'hE8};
    tbl[5] = '{cyc: 18, en: 1'b0, addr: 4'd15, valid: 1'b0, dn: 1'b1, cs: 8'hE8};

    rst = 1'b1;
    @(negedge clk);
    check_zero("reset");
    sweep();

`ifndef READ_DRIVER_LOOP_EN
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("hold_done",     32'(done),     1);
      chk("hold_valid",    32'(rd_valid), 0);
      chk("hold_rd_en",    32'(rd_en),    0);
      chk("hold_checksum", 32'(checksum), 32'hE8);
    end
`else
    for (int p = 0; p < 2; p++) begin
      push_sweep();
      for (int e = 1; e <= 18; e++) begin
        @(negedge clk);
        monitor();
        chk("loop_done", 32'(done), (e == 18) ? 1 : 0);
        if (e == 18) chk("loop_checksum", 32'(checksum), 32'hE8);
      end
      chk("loop_scoreboard_empty", sb.size(), 0);
    end
`endif

    // Reset mid-sweep at address 7.
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    push_sweep();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      monitor();
      if (rd_addr == 4'd7) break;
    end
    chk("reach_addr7", 32'(rd_addr), 7);
    #2 rst = 1'b1;
    #1 check_zero("async_reset");
    sb.delete();

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("held_rd_en",    32'(rd_en),    0);
      chk("held_valid",    32'(rd_valid), 0);
      chk("held_done",     32'(done),     0);
      chk("held_checksum", 32'(checksum), 0);
    end
    sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
